// File: rtl/alnsft_pkg.sv
// Shared types for the alignment-shift accumulator: command/state encodings and
// the control-side port bundles used inside the top.
package alnsft_pkg;

    typedef enum logic [1:0] {
        CMD_ACC   = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_CLR   = 2'd2,
        CMD_DRAIN = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Data fields are parameter-sized, so only the fixed-width control fields are bundled.
    typedef struct packed {
        logic valid;
        logic ready;
        cmd_e cmd;
    } alnsft_in_t;

    typedef struct packed {
        logic valid;
        logic ready;
    } alnsft_out_t;

endpackage

// File: rtl/alnsft_lane.sv
// One lane of the alignment shifter: right shift plus OR of the shifted-out bits.
// Sticky logic is only built when ALNSFT_STICKY_EN is defined; otherwise bit 0 is tied to 0.
module alnsft_lane #(
    parameter int ACC_W = 48,
    parameter int SFT_W = 6
) (
    input  logic [ACC_W-1:0] i_data,
    input  logic [SFT_W-1:0] i_sft,
    output logic [ACC_W:0]   o_aln
);

    logic [ACC_W-1:0] w_val;
    logic             w_sticky;

    // Shift amounts at or beyond ACC_W naturally yield zero.
    assign w_val = i_data >> i_sft;

`ifdef ALNSFT_STICKY_EN
    logic [ACC_W-1:0] w_mask;

    // Mask selects exactly the bits that fall off the bottom; all ones when sft >= ACC_W.
    assign w_mask   = ~({ACC_W{1'b1}} << i_sft);
    assign w_sticky = |(i_data & w_mask);
`else
    assign w_sticky = 1'b0;
`endif

    assign o_aln = {w_val, w_sticky};

endmodule

// File: rtl/alnsft_acc.sv
// Pipelined per-lane alignment shifter feeding per-lane accumulators with a drain port.
// Optional sticky collection is enabled by defining ALNSFT_STICKY_EN.
module alnsft_acc
    import alnsft_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 48,
    parameter int SFT_W = 6
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [1:0]                              in_cmd,
    input  logic [LANES-1:0]                        in_lane_en,
    input  logic [LANES*ACC_W-1:0]                  in_data,
    input  logic [LANES*SFT_W-1:0]                  in_sft,
    output logic                                    aln_valid,
    output logic [LANES*(ACC_W+1)-1:0]              aln,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
    output logic [ACC_W-1:0]                        out_acc
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    // Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
    alnsft_in_t                    w_in;
    alnsft_out_t                   w_out;
    logic                          w_fire;
    logic                          w_out_fire;
    logic [LANES*(ACC_W+1)-1:0]    w_aln;

    logic                          r_rdy;
    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [LW-1:0]                 r_out_lane;
    logic [LW-1:0]                 w_lane_nxt;

    logic                          r_a_valid;
    cmd_e                          r_a_cmd;
    logic [LANES-1:0]              r_a_en;
    logic [LANES*(ACC_W+1)-1:0]    r_aln;
    logic [ACC_W-1:0]              r_acc [LANES];

    assign w_in.valid  = in_valid;
    assign w_in.cmd    = cmd_e'(in_cmd);
    assign w_in.ready  = r_rdy && (r_state == ST_RUN);
    assign w_fire      = w_in.valid && w_in.ready;

    assign w_out.valid = (r_state == ST_DRAIN);
    assign w_out.ready = out_ready;
    assign w_out_fire  = w_out.valid && w_out.ready;

    assign in_ready    = w_in.ready;
    assign out_valid   = w_out.valid;
    assign out_lane    = r_out_lane;
    assign out_acc     = r_acc[r_out_lane];
    assign aln_valid   = r_a_valid;
    assign aln         = r_aln;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alnsft_lane #(
            .ACC_W (ACC_W),
            .SFT_W (SFT_W)
        ) u_lane (
            .i_data (in_data[g*ACC_W +: ACC_W]),
            .i_sft  (in_sft[g*SFT_W +: SFT_W]),
            .o_aln  (w_aln[g*(ACC_W+1) +: ACC_W+1])
        );
    end

    // Stage A: every accepted beat is registered, including CLR/DRAIN tokens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_valid <= 1'b0;
            r_a_cmd   <= CMD_ACC;
            r_a_en    <= '0;
            r_aln     <= '0;
        end else begin
            r_a_valid <= w_fire;
            if (w_fire) begin
                r_a_cmd <= w_in.cmd;
                r_a_en  <= in_lane_en;
                r_aln   <= w_aln;
            end
        end
    end

    // Stage B: single-cycle read-modify-write, so consecutive beats never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        end else if (r_a_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_a_en[i]) begin
                    case (r_a_cmd)
                        CMD_ACC:  r_acc[i] <= r_acc[i] + r_aln[i*(ACC_W+1)+1 +: ACC_W];
                        CMD_LOAD: r_acc[i] <= r_aln[i*(ACC_W+1)+1 +: ACC_W];
                        CMD_CLR:  r_acc[i] <= '0;
                        default:  r_acc[i] <= r_acc[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy      <= 1'b0;
            r_state    <= ST_RUN;
            r_out_lane <= '0;
        end else begin
            r_rdy      <= 1'b1;
            r_state    <= w_state_nxt;
            r_out_lane <= w_lane_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_out_lane;
        case (r_state)
            ST_RUN: begin
                if (w_fire && (w_in.cmd == CMD_DRAIN)) w_state_nxt = ST_PEND;
            end
            ST_PEND: begin
                // The DRAIN token in stage A means all earlier commands have already retired.
                if (r_a_valid && (r_a_cmd == CMD_DRAIN)) begin
                    w_state_nxt = ST_DRAIN;
                    w_lane_nxt  = '0;
                end
            end
            ST_DRAIN: begin
                if (w_out_fire) begin
                    if (r_out_lane == LW'(LANES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_lane_nxt  = '0;
                    end else begin
                        w_lane_nxt  = r_out_lane + LW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_lane_nxt  = '0;
            end
        endcase
    end

endmodule
